// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the UART receive FIFO: default geometry and ingress FSM encoding.
package uart_rx_fifo_pkg;

  localparam int AW_DEF = 4;
  localparam int DW_DEF = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Register array of 2**AW x DW with one synchronous write port and an asynchronous
// read-by-pointer port, giving first-word-fall-through head data.
module fifo_mem_fwft
  import uart_rx_fifo_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [2**AW];

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between a UART core holding register and the CPU read mux.
// Optional idle-timeout interrupt and tout port enabled by defining RXFIFO_TIMEOUT_EN.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int TOUT = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] u_q,
  input  logic          u_dv,
  output logic          u_rd,
  input  logic          rd,
  output logic [DW-1:0] q,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  input  logic [AW:0]   thr,
  output logic          irq
`ifdef RXFIFO_TIMEOUT_EN
  ,
  output logic          tout
`endif
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

  logic [1:0]    state_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [AW:0]   count_nxt_s;
  logic          empty_r;
  logic          full_r;
  logic          u_rd_r;
  logic          irq_r;
  logic          push_s;
  logic          pop_s;
  logic          thr_hit_s;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
  assign push_s    = (state_r == ST_IDLE) & u_dv & ~full_r & ~reset;
  assign pop_s     = rd & ~empty_r;
  assign thr_hit_s = (thr != {(AW+1){1'b0}}) & (count_r >= thr);

  // Next occupancy from the push/pop pair.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + ONE;
      2'b01:   count_nxt_s = count_r - ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Ingress handshake FSM and the one-cycle acknowledge to the core.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      u_rd_r  <= 1'b0;
    end else begin
      u_rd_r <= push_s;
      case (state_r)
        ST_IDLE: state_r <= push_s ? ST_ACK : ST_IDLE;
        ST_ACK:  state_r <= ST_WAIT;
        ST_WAIT: state_r <= u_dv ? ST_WAIT : ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Pointers and occupancy flags, all updated together so they stay consistent.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      if (pop_s)  rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      count_r <= count_nxt_s;
      empty_r <= (count_nxt_s == {(AW+1){1'b0}});
      full_r  <= (count_nxt_s == DEPTH);
    end
  end

`ifdef RXFIFO_TIMEOUT_EN
  // One extra bit beyond clog2(TOUT) so the counter can actually hold TOUT.
  localparam int          TW     = $clog2(TOUT + 1);
  localparam logic [TW-1:0] TOUT_C = TW'(TOUT);

  logic [TW-1:0] idle_cnt_r;
  logic          tout_s;

  assign tout_s = (idle_cnt_r == TOUT_C);
  assign tout   = tout_s;

  // Idle timer and interrupt: clears on any traffic or when empty, saturates at TOUT.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt_r <= {TW{1'b0}};
      irq_r      <= 1'b0;
    end else begin
      if (push_s | pop_s | empty_r) begin
        idle_cnt_r <= {TW{1'b0}};
      end else if (!tout_s) begin
        idle_cnt_r <= idle_cnt_r + {{(TW-1){1'b0}}, 1'b1};
      end else begin
        idle_cnt_r <= idle_cnt_r;
      end
      irq_r <= thr_hit_s | tout_s;
    end
  end
`else
  // Threshold interrupt, one cycle behind the registered count.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= thr_hit_s;
    end
  end
`endif

  fifo_mem_fwft #(.AW(AW), .DW(DW)) u_mem (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata (u_q),
    .raddr (rd_ptr_r),
    .rdata (q)
  );

  assign u_rd  = u_rd_r;
  assign count = count_r;
  assign empty = empty_r;
  assign full  = full_r;
  assign irq   = irq_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: bytes queued when offered, compared on pop.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] u_q;
  logic       u_dv;
  logic       u_rd;
  logic       rd;
  logic [7:0] q;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic [4:0] thr;
  logic       irq;
`ifdef RXFIFO_TIMEOUT_EN
  logic       tout;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] sbq[$];
  logic       irq_at_ack;

  uart_rx_fifo dut (
    .clk   (clk),
    .reset (reset),
    .u_q   (u_q),
    .u_dv  (u_dv),
    .u_rd  (u_rd),
    .rd    (rd),
    .q     (q),
    .count (count),
    .empty (empty),
    .full  (full),
    .thr   (thr),
    .irq   (irq)
`ifdef RXFIFO_TIMEOUT_EN
    ,
    .tout  (tout)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_urd(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (u_rd === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Core model: hold u_dv until acknowledged, then drop it and let the FSM return to IDLE.
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    u_q  = b;
    u_dv = 1'b1;
    sbq.push_back(b);
    wait_urd(40, ok);
    check_eq("u_rd_seen", {31'd0, ok}, 32'd1);
    irq_at_ack = irq;
    u_dv = 1'b0;
    @(negedge clk);
    check_eq("u_rd_pulse", {31'd0, u_rd}, 32'd0);
    @(negedge clk);
  endtask

  task automatic pop_byte();
    logic [7:0] e;
    e = sbq.pop_front();
    check_eq("q_order", {24'd0, q}, {24'd0, e});
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  initial begin
    bit ok;
    bit seen;
    logic [7:0] r;
    logic [7:0] e;

    reset = 1'b1; u_q = 8'h00; u_dv = 1'b0; rd = 1'b0; thr = 5'd0;
    repeat (2) @(negedge clk);
    check_eq("rst_count", {27'd0, count}, 32'd0);
    check_eq("rst_empty", {31'd0, empty}, 32'd1);
    check_eq("rst_full",  {31'd0, full},  32'd0);
    check_eq("rst_u_rd",  {31'd0, u_rd},  32'd0);
    check_eq("rst_irq",   {31'd0, irq},   32'd0);
    reset = 1'b0;
    @(negedge clk);

    // single byte
    send_byte(8'h5A);
    check_eq("one_count", {27'd0, count}, 32'd1);
    check_eq("one_empty", {31'd0, empty}, 32'd0);
    check_eq("one_q", {24'd0, q}, 32'h5A);
    pop_byte();
    check_eq("one_pop_count", {27'd0, count}, 32'd0);
    check_eq("one_pop_empty", {31'd0, empty}, 32'd1);

    // fill, backpressure, then accept after a pop
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    check_eq("fill_full", {31'd0, full}, 32'd1);
    check_eq("fill_count", {27'd0, count}, 32'd16);
    u_q = 8'hAA; u_dv = 1'b1; sbq.push_back(8'hAA);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (u_rd) seen = 1'b1;
    end
    check_eq("no_urd_when_full", {31'd0, seen}, 32'd0);
    pop_byte();
    check_eq("no_push_same_cycle", {31'd0, u_rd}, 32'd0);
    wait_urd(10, ok);
    check_eq("urd_after_pop", {31'd0, ok}, 32'd1);
    u_dv = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("refill_count", {27'd0, count}, 32'd16);
    repeat (16) pop_byte();
    check_eq("drain_empty", {31'd0, empty}, 32'd1);

    // wrap and order with random data
    repeat (10) begin r = 8'($urandom()); send_byte(r); end
    check_eq("wrap10_count", {27'd0, count}, 32'd10);
    repeat (10) pop_byte();
    repeat (12) begin r = 8'($urandom()); send_byte(r); end
    check_eq("wrap12_count", {27'd0, count}, 32'd12);
    repeat (12) pop_byte();
    check_eq("wrap_empty", {31'd0, empty}, 32'd1);

    // simultaneous push and pop at count 5
    repeat (5) begin r = 8'($urandom()); send_byte(r); end
    u_q = 8'h77; u_dv = 1'b1; sbq.push_back(8'h77);
    e = sbq.pop_front();
    check_eq("sim_q_before", {24'd0, q}, {24'd0, e});
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    check_eq("sim_u_rd", {31'd0, u_rd}, 32'd1);
    check_eq("sim_count", {27'd0, count}, 32'd5);
    check_eq("sim_q_after", {24'd0, q}, {24'd0, sbq[0]});
    u_dv = 1'b0;
    repeat (2) @(negedge clk);
    repeat (5) pop_byte();
    check_eq("sim_empty", {31'd0, empty}, 32'd1);

    // threshold interrupt
    thr = 5'd4;
    repeat (3) begin r = 8'($urandom()); send_byte(r); end
    check_eq("thr_below", {31'd0, irq}, 32'd0);
    send_byte(8'h44);
    check_eq("thr_irq_lag", {31'd0, irq_at_ack}, 32'd0);
    check_eq("thr_hit", {31'd0, irq}, 32'd1);
    pop_byte();
    check_eq("thr_pop_lag", {31'd0, irq}, 32'd1);
    @(negedge clk);
    check_eq("thr_pop_clear", {31'd0, irq}, 32'd0);
    repeat (13) begin r = 8'($urandom()); send_byte(r); end
    check_eq("thr_full_count", {27'd0, count}, 32'd16);
    thr = 5'd0;
    @(negedge clk);
    check_eq("thr0_no_irq", {31'd0, irq}, 32'd0);
    thr = 5'd17;
    @(negedge clk);
    check_eq("thr17_no_irq", {31'd0, irq}, 32'd0);
    thr = 5'd16;
    @(negedge clk);
    check_eq("thr16_irq", {31'd0, irq}, 32'd1);
    thr = 5'd4;
    repeat (10) pop_byte();

    // reset mid-stream with FSM in WAIT and u_dv still high
    u_q = 8'hC3; u_dv = 1'b1;
    wait_urd(10, ok);
    check_eq("pre_rst_ack", {31'd0, ok}, 32'd1);
    @(negedge clk);
    check_eq("pre_rst_count", {27'd0, count}, 32'd7);
    check_eq("pre_rst_irq", {31'd0, irq}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_count", {27'd0, count}, 32'd0);
    check_eq("mid_rst_empty", {31'd0, empty}, 32'd1);
    check_eq("mid_rst_u_rd",  {31'd0, u_rd},  32'd0);
    check_eq("mid_rst_irq",   {31'd0, irq},   32'd0);
    sbq.delete();
    sbq.push_back(8'hC3);
    reset = 1'b0;
    wait_urd(10, ok);
    check_eq("post_rst_reaccept", {31'd0, ok}, 32'd1);
    u_dv = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("post_rst_count", {27'd0, count}, 32'd1);
    pop_byte();
    check_eq("post_rst_empty", {31'd0, empty}, 32'd1);

`ifdef RXFIFO_TIMEOUT_EN
    thr = 5'd0;
    send_byte(8'h3C);
    repeat (1022) @(negedge clk);
    check_eq("tout_flag", {31'd0, tout}, 32'd1);
    check_eq("tout_irq_lag", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check_eq("tout_irq", {31'd0, irq}, 32'd1);
    pop_byte();
    @(negedge clk);
    check_eq("tout_clear", {31'd0, irq}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
